// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the elastic skid pipeline register.
// The state encoding doubles as the held-word count.
package pipe_skid_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Upstream may offer a word next cycle unless both slots will be occupied.
    function automatic logic ready_for(input state_t s);
        return (s != ST_FULL);
    endfunction

    // Output side presents a word whenever at least the main slot is occupied.
    function automatic logic valid_for(input state_t s);
        return (s != ST_EMPTY);
    endfunction

endpackage

// File: rtl/pipe_skid_reg_skid_slot.sv
// One N-bit storage slot with synchronous clear (dominant) and load enable.
module pipe_skid_reg_skid_slot #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] q_r;

    // Slot register: clear wins over load, otherwise hold.
    always_ff @(posedge clk) begin
        if (clear) begin
            q_r <= {N{1'b0}};
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register: main slot drives the output, skid slot absorbs
// one beat of downstream stall so in_ready can be a pure register.
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic [1:0]   count
);

    state_t       state_r;
    state_t       state_nxt_s;
    logic         in_ready_r;
    logic         out_valid_r;
    logic         acc_s;
    logic         take_s;
    logic         main_load_s;
    logic         skid_load_s;
    logic [N-1:0] main_d_s;
    logic [N-1:0] main_q_s;
    logic [N-1:0] skid_q_s;

    assign acc_s  = in_valid & in_ready_r;
    assign take_s = out_valid_r & out_ready;

    // Next-state and slot-load decode; flush abandons both handshakes.
    always_comb begin
        state_nxt_s = state_r;
        main_load_s = 1'b0;
        skid_load_s = 1'b0;
        main_d_s    = in_data;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (acc_s) begin
                        state_nxt_s = ST_ONE;
                        main_load_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (acc_s && take_s) begin
                        state_nxt_s = ST_ONE;
                        main_load_s = 1'b1;
                    end else if (acc_s) begin
                        state_nxt_s = ST_FULL;
                        skid_load_s = 1'b1;
                    end else if (take_s) begin
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so only the drain path exists.
                    if (take_s) begin
                        state_nxt_s = ST_ONE;
                        main_load_s = 1'b1;
                        main_d_s    = skid_q_s;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Control state and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= ready_for(state_nxt_s);
            out_valid_r <= valid_for(state_nxt_s);
        end
    end

    pipe_skid_reg_skid_slot #(.N(N)) u_main (
        .clk   (clk),
        .clear (reset),
        .load  (main_load_s),
        .d     (main_d_s),
        .q     (main_q_s)
    );

    pipe_skid_reg_skid_slot #(.N(N)) u_skid (
        .clk   (clk),
        .clear (reset),
        .load  (skid_load_s),
        .d     (in_data),
        .q     (skid_q_s)
    );

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = main_q_s;
    assign count     = state_r;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed vector table plus streaming and randomized scoreboard runs for
// the elastic skid pipeline register.
module tb_pipe_skid_reg;

    localparam int N = 16;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic [1:0]   count;

    int n_cmp;
    int n_bad;

    pipe_skid_reg #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         fl;
        logic         iv;
        logic [N-1:0] d;
        logic         ordy;
        logic         ov;
        logic         ir;
        logic [1:0]   c;
        logic [N-1:0] od;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic fl, input logic iv,
                        input logic [N-1:0] d, input logic ordy);
        reset     = rst;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ov, input logic ir,
                           input logic [1:0] c, input logic [N-1:0] od, input logic check_data);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
        chk({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, ir});
        chk({tag, ".count"},     {30'd0, count},     {30'd0, c});
        if (check_data) begin
            chk({tag, ".out_data"}, {16'd0, out_data}, {16'd0, od});
        end
    endtask

    logic [N-1:0] model_q [$];
    logic         model_rdy;
    logic         r_iv;
    logic         r_or;
    logic [N-1:0] r_d;
    logic         r_acc;
    logic         r_take;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = 16'h0000;
        out_ready = 1'b0;

        //           rst   fl    iv    d          ordy   ov    ir    c     od
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0000};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b1, 2'd1, 16'h0001};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b1, 2'd1, 16'h0002};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd0, 16'h0002};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b1, 2'd1, 16'hAAAA};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'hBBBB, 1'b0, 1'b1, 1'b0, 2'd2, 16'hAAAA};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'hCCCC, 1'b0, 1'b1, 1'b0, 2'd2, 16'hAAAA};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 2'd1, 16'hBBBB};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd0, 16'hBBBB};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 16'h1111, 1'b0, 1'b1, 1'b1, 2'd1, 16'h1111};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, 2'd2, 16'h1111};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 16'h3333, 1'b0, 1'b0, 1'b1, 2'd0, 16'h1111};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 16'h4444, 1'b0, 1'b0, 1'b1, 2'd0, 16'h1111};
        vecs[14] = '{1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b1, 1'b1, 2'd1, 16'h5555};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 16'h6666, 1'b0, 1'b1, 1'b0, 2'd2, 16'h5555};
        vecs[16] = '{1'b1, 1'b1, 1'b1, 16'hDDDD, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0000};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 16'hEEEE, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0000};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 16'h7777, 1'b1, 1'b1, 1'b1, 2'd1, 16'h7777};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 16'h8888, 1'b0, 1'b1, 1'b0, 2'd2, 16'h7777};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 2'd1, 16'h8888};
        vecs[21] = '{1'b0, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b1, 1'b1, 2'd1, 16'h9999};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'd1, 16'h9999};

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].ordy);
            chk_all($sformatf("vec%0d", i), vecs[i].ov, vecs[i].ir, vecs[i].c, vecs[i].od, 1'b1);
        end

        // Full-rate stream: each word shows up right after its accept edge.
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk_all("stream_rst", 1'b0, 1'b1, 2'd0, 16'h0000, 1'b1);
        for (int w = 1; w <= 16; w++) begin
            step(1'b0, 1'b0, 1'b1, w[N-1:0], 1'b1);
            chk_all($sformatf("stream%0d", w), 1'b1, 1'b1, 2'd1, w[N-1:0], 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk_all("stream_end", 1'b0, 1'b1, 2'd0, 16'h0010, 1'b1);

        // Random traffic against a queue model.
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        model_q.delete();
        model_rdy = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            r_iv = 1'($urandom_range(0, 1));
            r_or = 1'($urandom_range(0, 1));
            r_d  = 16'($urandom);
            r_acc  = r_iv & model_rdy;
            r_take = (model_q.size() > 0) & r_or;
            step(1'b0, 1'b0, r_iv, r_d, r_or);
            if (r_take) begin
                void'(model_q.pop_front());
            end
            if (r_acc) begin
                model_q.push_back(r_d);
            end
            model_rdy = (model_q.size() != 2);
            chk_all($sformatf("rand%0d", cyc), (model_q.size() > 0), model_rdy,
                    2'(model_q.size()), (model_q.size() > 0) ? model_q[0] : 16'h0000,
                    (model_q.size() > 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
